// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single combinational full-adder bit-slice.
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Out,
  output logic Cout
);

  assign Out  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds A + B + Cin one bit per clock, LSB first, through a
// single full-adder slice and a carry flip-flop. Start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 most recent sum bits; the current slice sum is
  // prepended to form the full WIDTH-bit result on the last shift edge.
  logic [WIDTH-2:0] s_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic             slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] s_cat;

  full_adder_1bit u_slice (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Out  (slice_sum),
    .Cout (slice_cout)
  );

  // Sum register after this edge's bit enters at the MSB.
  assign s_cat = {slice_sum, s_sh};

  // Controller FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Out   <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            s_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_cat[WIDTH-1:1];
          carry <= slice_cout;
          if (cnt == CNT_LAST) begin
            // Completion edge: the counter holds rather than wrapping.
            Out   <= s_cat;
            Cout  <= slice_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): reset state, directed
// vector table, exhaustive sweep, random operands and handshake corner cases.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] Out;
  logic         Cout;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Out   (Out),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_out;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[5];

  // Reference: plain integer addition, result split into sum and carry.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return (W + 1)'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a request and return just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      if (lat >= 20) begin
        chk("done_timeout", 32'(lat), 32'(W));
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W-1:0] eo, input logic ec);
    int lat;
    start_op(a, b, c);
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'(W));
    chk({name, "_out"}, 32'(Out), 32'(eo));
    chk({name, "_cout"}, 32'(Cout), 32'(ec));
  endtask

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_excl: busy=%0b done=%0b at %0t", busy, done, $time);
      end
    end
  end

  initial begin
    logic [W:0] r;
    logic [W-1:0] held;
    int lat;
    int pulses;

    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{4'b1000, 4'b0001, 1'b0, 4'b1001, 1'b0};
    vecs[2] = '{4'b1111, 4'b1001, 1'b0, 4'b1000, 1'b1};
    vecs[3] = '{4'b1011, 4'b1010, 1'b0, 4'b0101, 1'b1};
    vecs[4] = '{4'b0110, 4'b0011, 1'b1, 4'b1010, 1'b0};

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(Out), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    mon_en = 1'b1;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].exp_out, vecs[i].exp_cout);
      @(posedge clk);
      #1 chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Exhaustive sweep against the reference.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          r = ref_add(W'(a), W'(b), 1'(c));
          start_op(W'(a), W'(b), 1'(c));
          wait_done(lat);
          chk("sweep_sum", {27'd0, Cout, Out}, 32'(r));
        end
      end
    end

    // Random operands, with a random idle gap between requests.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      r = ref_add(ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_check("rand", ra, rb, rc, r[W-1:0], r[W]);
    end

    // Ignored start during SHIFT; Out holds until completion.
    held = Out;
    start_op(4'b1110, 4'b0101, 1'b0);
    @(posedge clk);                       // edge 1
    @(negedge clk);
    A = 4'b0001; B = 4'b0001; Cin = 1'b0; start = 1'b1;
    @(posedge clk);                       // edge 2
    #1 start = 1'b0;
    chk("ign_hold_e2", 32'(Out), 32'(held));
    @(posedge clk);                       // edge 3
    #1 chk("ign_hold_e3", 32'(Out), 32'(held));
    chk("ign_nodone_e3", 32'(done), 32'd0);
    @(posedge clk);                       // edge 4
    #1 chk("ign_done", 32'(done), 32'd1);
    chk("ign_out", 32'(Out), 32'b0011);
    chk("ign_cout", 32'(Cout), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    chk("ign_dropped", 32'(pulses), 32'd0);
    chk("ign_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: request made during the DONE cycle.
    run_check("b2b_first", 4'b1000, 4'b0111, 1'b0, 4'b1111, 1'b0);
    A = 4'b0100; B = 4'b0101; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(lat);
    chk("b2b_spacing", 32'(lat + 1), 32'd5);
    chk("b2b_out", 32'(Out), 32'b1001);
    chk("b2b_cout", 32'(Cout), 32'd0);

    // Reset asserted at shift edge 2.
    start_op(4'b1011, 4'b0110, 1'b0);
    @(posedge clk);                       // edge 1
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);                       // edge 2 sees reset
    #1 rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_out", 32'(Out), 32'd0);
    chk("mid_rst_cout", 32'(Cout), 32'd0);
    mon_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (done || busy) pulses++;
    end
    chk("mid_rst_idle", 32'(pulses), 32'd0);
    run_check("post_rst", 4'b0010, 4'b0111, 1'b0, 4'b1001, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
